// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer and control unit:
// opcode/funct encodings, phase indices, the one-hot phase type and the
// instruction class enumeration.
package mips_pkg;

  // Width of the one-hot phase vector p[4:0].
  localparam int PHASE_W = 5;

  // Primary opcode field values (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function field value (IR[5:0]) for add.
  localparam logic [5:0] FUNCT_ADD = 6'b100000;

  // Phase indices; a phase index i corresponds to p[i] being set.
  localparam logic [2:0] P0 = 3'd0;
  localparam logic [2:0] P1 = 3'd1;
  localparam logic [2:0] P2 = 3'd2;
  localparam logic [2:0] P3 = 3'd3;
  localparam logic [2:0] P4 = 3'd4;

  // One-hot phase encoding used directly as the sequencer state.
  typedef enum logic [PHASE_W-1:0] {
    PH0 = 5'b00001,
    PH1 = 5'b00010,
    PH2 = 5'b00100,
    PH3 = 5'b01000,
    PH4 = 5'b10000
  } phase_t;

  // Instruction classes; each class owns one phase sequence length.
  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [PHASE_W-1:0] PHASE_ONE = PHASE_W'(1);

  // Convert a phase index into its one-hot phase vector.
  function automatic logic [PHASE_W-1:0] phase_onehot(input logic [2:0] idx);
    return PHASE_ONE << idx;
  endfunction

  // Classes whose p3 is a data-memory access and therefore waits on mem_ready.
  function automatic logic class_has_mem_p3(input instr_class_t cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage

// File: rtl/phase_sequencer_instr_class.sv
// Combinational instruction classifier. Maps (op, funct) to an instruction
// class and the index of the final phase of that class. Shared with the
// control unit decode so that class boundaries live in one place.
module instr_class
  import mips_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   irfunc,
  output instr_class_t cls,
  output logic [2:0]   final_phase
);

  // Decode opcode (and funct for R-type) into a class, then the class into
  // its last phase. Anything unrecognised stops after p1.
  always_comb begin
    cls         = CLS_ILLEGAL;
    final_phase = P1;

    case (op)
      OP_RTYPE: begin
        if (irfunc == FUNCT_ADD) begin
          cls = CLS_ALU;
        end
      end
      OP_LW:         cls = CLS_LOAD;
      OP_SW:         cls = CLS_STORE;
      OP_BEQ, OP_BNE: cls = CLS_BRANCH;
      OP_J, OP_JAL:  cls = CLS_JUMP;
      default:       cls = CLS_ILLEGAL;
    endcase

    case (cls)
      CLS_ALU:     final_phase = P4;
      CLS_LOAD:    final_phase = P4;
      CLS_STORE:   final_phase = P3;
      CLS_BRANCH:  final_phase = P2;
      CLS_JUMP:    final_phase = P4;
      default:     final_phase = P1;
    endcase
  end

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer for the multi-cycle MIPS control unit. Produces the one-hot
// phase vector, holds the instruction register, stalls on memory phases,
// flags retirement / illegal encodings and keeps cycle and retire counters.
module phase_sequencer
  import mips_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               mem_ready,
  output logic [PHASE_W-1:0] p,
  output logic [5:0]         op,
  output logic [5:0]         irfunc,
  output logic [INSTR_W-1:0] instr,
  output logic               last_phase,
  output logic               retire,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  phase_t             phase_reg, phase_next;
  logic [INSTR_W-1:0] ir_reg, ir_next;
  logic               retire_reg, retire_next;
  logic               illegal_reg, illegal_next;
  logic [CNT_W-1:0]   cycle_reg;
  logic [CNT_W-1:0]   instret_reg, instret_next;

  instr_class_t       cls;
  logic [2:0]         final_idx;
  logic [PHASE_W-1:0] final_onehot;
  logic               is_last;
  logic               is_stall;
  logic               advance;

  // Class and final phase always come from the registered IR.
  instr_class u_class (
    .op          (ir_reg[31:26]),
    .irfunc      (ir_reg[5:0]),
    .cls         (cls),
    .final_phase (final_idx)
  );

  // Final phase never decodes to p0, so last_phase is naturally low in p0.
  assign final_onehot = phase_onehot(final_idx);
  assign is_last      = (phase_reg == final_onehot);

  // Fetch (p0) always waits for memory; p3 waits only for loads and stores.
  assign is_stall = (phase_reg == PH0) ||
                    ((phase_reg == PH3) && class_has_mem_p3(cls));
  assign advance  = !is_stall || mem_ready;

  // State register: phase, IR, event pulses and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg   <= PH0;
      ir_reg      <= '0;
      retire_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      cycle_reg   <= '0;
      instret_reg <= '0;
    end else begin
      phase_reg   <= phase_next;
      ir_reg      <= ir_next;
      retire_reg  <= retire_next;
      illegal_reg <= illegal_next;
      cycle_reg   <= cycle_reg + CNT_ONE;
      instret_reg <= instret_next;
    end
  end

  // Next phase, IR capture and retire/illegal decisions for this cycle.
  always_comb begin
    phase_next   = phase_reg;
    ir_next      = ir_reg;
    retire_next  = 1'b0;
    illegal_next = 1'b0;
    instret_next = instret_reg;

    case (phase_reg)
      PH0: begin
        if (advance) begin
          ir_next    = instr_in;
          phase_next = PH1;
        end
      end
      PH1, PH2, PH3, PH4: begin
        if (advance) begin
          if (is_last) begin
            phase_next = PH0;
            if (cls == CLS_ILLEGAL) begin
              illegal_next = 1'b1;
            end else begin
              retire_next  = 1'b1;
              instret_next = instret_reg + CNT_ONE;
            end
          end else begin
            case (phase_reg)
              PH1:     phase_next = PH2;
              PH2:     phase_next = PH3;
              PH3:     phase_next = PH4;
              default: phase_next = PH0;
            endcase
          end
        end
      end
      // A corrupted (non-one-hot) phase restarts at fetch without retiring.
      default: phase_next = PH0;
    endcase
  end

  assign p           = phase_reg;
  assign op          = ir_reg[31:26];
  assign irfunc      = ir_reg[5:0];
  assign instr       = ir_reg;
  assign last_phase  = is_last;
  assign retire      = retire_reg;
  assign illegal_op  = illegal_reg;
  assign cycle_cnt   = cycle_reg;
  assign instret_cnt = instret_reg;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: an instruction-level model checked
// every cycle, plus hand-computed expectations for each directed scenario.
// A second instance with 2-bit counters exercises counter wrap-around.
module tb_phase_sequencer;

  localparam logic [31:0] I_ADD  = 32'h012A4020;
  localparam logic [31:0] I_BEQ  = 32'h112A0003;
  localparam logic [31:0] I_SW   = 32'hAD280004;
  localparam logic [31:0] I_LW   = 32'h8D280004;
  localparam logic [31:0] I_ILL1 = 32'hFC000000;
  localparam logic [31:0] I_ILL2 = 32'h00000022;
  localparam logic [31:0] I_JMP  = 32'h08000010;
  localparam logic [31:0] I_JUNK = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_in = '0;
  logic        mem_ready = 1'b1;

  logic [4:0]  p;
  logic [5:0]  op, irfunc;
  logic [31:0] instr;
  logic        last_phase, retire, illegal_op;
  logic [31:0] cycle_cnt, instret_cnt;

  logic [4:0]  w_p;
  logic [5:0]  w_op, w_irfunc;
  logic [31:0] w_instr;
  logic        w_last_phase, w_retire, w_illegal_op;
  logic [1:0]  w_cycle_cnt, w_instret_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.CNT_W(32), .INSTR_W(32)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .mem_ready(mem_ready),
    .p(p), .op(op), .irfunc(irfunc), .instr(instr), .last_phase(last_phase),
    .retire(retire), .illegal_op(illegal_op), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  phase_sequencer #(.CNT_W(2), .INSTR_W(32)) dut_w (
    .clk(clk), .reset(reset), .instr_in(instr_in), .mem_ready(mem_ready),
    .p(w_p), .op(w_op), .irfunc(w_irfunc), .instr(w_instr),
    .last_phase(w_last_phase), .retire(w_retire), .illegal_op(w_illegal_op),
    .cycle_cnt(w_cycle_cnt), .instret_cnt(w_instret_cnt)
  );

  // ---------------- instruction-level model ----------------
  int          m_ph = 0;
  logic [31:0] m_ir = '0;
  logic        m_ret = 1'b0;
  logic        m_ill = 1'b0;
  logic [31:0] m_cyc = '0;
  logic [31:0] m_icnt = '0;
  bit          m_valid = 1'b0;

  // Index of the last phase each instruction runs (1 means unsupported).
  function automatic int final_phase_of(input logic [31:0] w);
    case (w[31:26])
      6'b000000:            return (w[5:0] == 6'b100000) ? 4 : 1;
      6'b100011:            return 4;
      6'b101011:            return 3;
      6'b000100, 6'b000101: return 2;
      6'b000010, 6'b000011: return 4;
      default:              return 1;
    endcase
  endfunction

  function automatic bit waits_for_mem(input int ph, input logic [31:0] w);
    return (ph == 0) || (ph == 3 && (w[31:26] == 6'b100011 || w[31:26] == 6'b101011));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ph = 0; m_ir = '0; m_ret = 1'b0; m_ill = 1'b0;
      m_cyc = '0; m_icnt = '0; m_valid = 1'b1;
    end else begin
      m_cyc = m_cyc + 32'd1;
      m_ret = 1'b0;
      m_ill = 1'b0;
      if (!waits_for_mem(m_ph, m_ir) || mem_ready) begin
        if (m_ph == 0) begin
          m_ir = instr_in;
          m_ph = 1;
        end else if (m_ph == final_phase_of(m_ir)) begin
          m_ph = 0;
          if (final_phase_of(m_ir) == 1) m_ill = 1'b1;
          else begin
            m_ret  = 1'b1;
            m_icnt = m_icnt + 32'd1;
          end
        end else begin
          m_ph = m_ph + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  logic [4:0] exp_p;
  logic       exp_last;

  always @(negedge clk) begin
    if (m_valid) begin
      exp_p    = 5'b00001 << m_ph;
      exp_last = (m_ph != 0) && (m_ph == final_phase_of(m_ir));
      tests++;
      if (p !== exp_p || op !== m_ir[31:26] || irfunc !== m_ir[5:0] ||
          instr !== m_ir || last_phase !== exp_last || retire !== m_ret ||
          illegal_op !== m_ill || cycle_cnt !== m_cyc || instret_cnt !== m_icnt) begin
        fails++;
        $display("FAIL model_cycle t=%0t got p=%b ir=%h last=%b ret=%b ill=%b cyc=%0d icnt=%0d want p=%b ir=%h last=%b ret=%b ill=%b cyc=%0d icnt=%0d",
                 $time, p, instr, last_phase, retire, illegal_op, cycle_cnt, instret_cnt,
                 exp_p, m_ir, exp_last, m_ret, m_ill, m_cyc, m_icnt);
      end
      tests++;
      if (w_p !== exp_p || w_instr !== m_ir || w_retire !== m_ret ||
          w_cycle_cnt !== m_cyc[1:0] || w_instret_cnt !== m_icnt[1:0]) begin
        fails++;
        $display("FAIL model_narrow t=%0t got p=%b cyc=%0d icnt=%0d want p=%b cyc=%0d icnt=%0d",
                 $time, w_p, w_cycle_cnt, w_instret_cnt, exp_p, m_cyc[1:0], m_icnt[1:0]);
      end
      if (m_ret) $display("[TB] t=%0t retire instr=%h instret=%0d cycle=%0d", $time, m_ir, m_icnt, m_cyc);
      if (m_ill) $display("[TB] t=%0t illegal instr=%h cycle=%0d", $time, m_ir, m_cyc);
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then move to the next sampling point.
  task automatic step(input logic [31:0] ins, input logic mr);
    instr_in  = ins;
    mem_ready = mr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b1;
    instr_in  = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state, then add: p0..p4 and retire on the next p0.
    do_reset();
    check("reset_p", {27'd0, p}, 32'h1);
    check("reset_ir", instr, 32'h0);
    check("reset_cycle", cycle_cnt, 32'd0);
    check("reset_instret", instret_cnt, 32'd0);
    check("reset_pulses", {30'd0, retire, illegal_op}, 32'd0);
    step(I_ADD, 1'b1);  check("add_p1", {27'd0, p}, 32'h02);
    step(I_JUNK, 1'b1); check("add_p2", {27'd0, p}, 32'h04);
    step(I_JUNK, 1'b1); check("add_p3", {27'd0, p}, 32'h08);
    step(I_JUNK, 1'b1); check("add_p4", {27'd0, p}, 32'h10);
    check("add_last", {31'd0, last_phase}, 32'd1);
    step(I_JUNK, 1'b1); check("add_wrap_p", {27'd0, p}, 32'h01);
    check("add_retire", {31'd0, retire}, 32'd1);
    check("add_instret", instret_cnt, 32'd1);
    check("add_cycle", cycle_cnt, 32'd5);

    // beq then sw, no stalls.
    do_reset();
    step(I_BEQ, 1'b1);
    step(I_JUNK, 1'b1); check("beq_last_p2", {26'd0, last_phase, p}, 32'h24);
    step(I_JUNK, 1'b1); check("beq_retire", {31'd0, retire}, 32'd1);
    check("beq_cycle", cycle_cnt, 32'd3);
    step(I_SW, 1'b1);
    step(I_JUNK, 1'b1);
    step(I_JUNK, 1'b1); check("sw_last_p3", {26'd0, last_phase, p}, 32'h28);
    step(I_JUNK, 1'b1); check("sw_retire", {31'd0, retire}, 32'd1);
    check("bs_instret", instret_cnt, 32'd2);
    check("bs_cycle", cycle_cnt, 32'd7);

    // lw with fetch and data-memory stalls; mem_ready low in p1/p2/p4.
    do_reset();
    step(I_LW, 1'b0);   check("lw_p0_hold1", {27'd0, p}, 32'h01);
    step(I_LW, 1'b0);   check("lw_p0_hold2", {27'd0, p}, 32'h01);
    step(I_LW, 1'b1);   check("lw_op_p1", {26'd0, op}, 32'h23);
    step(I_JUNK, 1'b0); check("lw_p2_nostall", {27'd0, p}, 32'h04);
    step(I_JUNK, 1'b0); check("lw_p3", {27'd0, p}, 32'h08);
    step(I_JUNK, 1'b0);
    step(I_JUNK, 1'b0);
    step(I_JUNK, 1'b0); check("lw_p3_hold", {27'd0, p}, 32'h08);
    step(I_JUNK, 1'b1); check("lw_p4", {27'd0, p}, 32'h10);
    check("lw_op_p4", {26'd0, op}, 32'h23);
    step(I_JUNK, 1'b0); check("lw_retire", {31'd0, retire}, 32'd1);
    check("lw_cycle", cycle_cnt, 32'd10);

    // Two unsupported encodings.
    do_reset();
    step(I_ILL1, 1'b1); check("ill1_last_p1", {26'd0, last_phase, p}, 32'h22);
    step(I_JUNK, 1'b1); check("ill1_pulse", {29'd0, illegal_op, retire, p[0]}, 32'h5);
    step(I_ILL2, 1'b1); check("ill2_p1", {26'd0, illegal_op, p}, 32'h02);
    step(I_JUNK, 1'b1); check("ill2_pulse", {29'd0, illegal_op, retire, p[0]}, 32'h5);
    check("ill_instret", instret_cnt, 32'd0);

    // Reset during p3 of j discards it; the next fetch runs normally.
    do_reset();
    step(I_JMP, 1'b1);
    step(I_JUNK, 1'b1);
    step(I_JUNK, 1'b1); check("j_p3", {27'd0, p}, 32'h08);
    do_reset();
    check("jrst_p", {27'd0, p}, 32'h01);
    check("jrst_ir", instr, 32'h0);
    check("jrst_cnt", cycle_cnt | instret_cnt, 32'h0);
    check("jrst_retire", {31'd0, retire}, 32'd0);
    step(I_ADD, 1'b1);
    repeat (4) step(I_JUNK, 1'b1);
    check("jrst_add_retire", {31'd0, retire}, 32'd1);
    check("jrst_add_instret", instret_cnt, 32'd1);

    // Counter wrap on the 2-bit instance while adds run back to back.
    do_reset();
    repeat (17) step(I_ADD, 1'b1);
    check("wrap_cycle17", {30'd0, w_cycle_cnt}, 32'd1);
    check("wide_cycle17", cycle_cnt, 32'd17);
    repeat (3) step(I_ADD, 1'b1);
    check("wrap_instret", {30'd0, w_instret_cnt}, 32'd0);
    check("wide_instret", instret_cnt, 32'd4);
    check("wrap_cycle20", {30'd0, w_cycle_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Drives the one-hot phase vector p[4:0] and the op/irfunc fields consumed by the multi-cycle MIPS control unit. It is the producer side of that interface.
- Latches the fetched instruction into the instruction register (IR) at the end of p0. Decides per instruction class how many phases to run, stalls on memory phases, and keeps cycle and retired-instruction counters.
- Sits between instruction memory / datapath and the control unit.

Parameters:
- CNT_W, 32, width of cycle_cnt and instret_cnt.
- INSTR_W, 32, instruction width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_in  input  INSTR_W  instruction word from instruction memory, valid when mem_ready=1 during p0.
- mem_ready  input  1  memory access complete this cycle.
- p  output  5  one-hot phase; p[0]=1 means phase p0.
- op  output  6  IR[31:26].
- irfunc  output  6  IR[5:0].
- instr  output  INSTR_W  full IR.
- last_phase  output  1  current phase is the final phase of the current instruction.
- retire  output  1  one-cycle pulse when an instruction completes.
- illegal_op  output  1  one-cycle pulse, unsupported encoding detected.
- cycle_cnt  output  CNT_W  clock cycles since reset.
- instret_cnt  output  CNT_W  instructions retired since reset.

Behaviour:
- Reset (synchronous, active-high):
  - p=5'b00001, IR=0, retire=0, illegal_op=0, both counters 0.
  - Reset asserted mid-instruction discards that instruction. No retire and no instret increment for it.
- Phase sequences, decoded from the registered IR:
  - add (op 000000, funct 100000): p0-p1-p2-p3-p4.
  - lw (100011): p0-p1-p2-p3-p4.
  - sw (101011): p0-p1-p2-p3.
  - beq (000100) and bne (000101): p0-p1-p2.
  - j (000010) and jal (000011): p0-p1-p2-p3-p4.
  - Any other encoding, including op 000000 with funct != 100000: p0-p1, then illegal_op pulses for the cycle after p1 and the sequence returns to p0. No retire.
- Advance rule: each phase lasts 1 cycle, except the stall phases below.
  - Stall phases: p0 always; p3 when lw or sw.
  - In a stall phase, p holds while mem_ready=0 and advances in the cycle mem_ready=1.
  - mem_ready is ignored in non-stall phases.
- IR load: IR <= instr_in at the clock edge ending p0 (p[0] & mem_ready). IR is stable during p1..p4. op, irfunc and instr are driven combinationally from IR.
- last_phase is combinational: high when p equals the final phase of the decoded class. In p0 it is always 0.
- Wrap: when last_phase=1 and the phase advances, the next p is p0.
- retire:
  - Registered; pulses 1 cycle after the edge leaving the last phase, i.e. concurrent with the next p0's first cycle.
  - instret_cnt increments on that same edge.
  - Counter width rule: both counters wrap modulo 2^CNT_W with no saturation.
- cycle_cnt increments every non-reset cycle, including stalls.
- p is always exactly one-hot. Any non-one-hot state recovers to p0 on the next edge, with no retire.
- Minimum instruction time (no stalls): beq 3 cycles, sw 4 cycles, add/lw/j/jal 5 cycles.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL;
  - FUNCT_ADD;
  - phase index constants P0..P4 and PHASE_W=5;
  - enum instr_class_t {CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL}.
- One combinational sub-module, instr_class, maps (op, irfunc) to instr_class_t and a final-phase index. It is shared with the control unit's decode so class definitions stay single-sourced.

Test Plan:
- Reset, then fetch add 0x012A4020 with mem_ready=1 always:
  - p walks 00001, 00010, 00100, 01000, 10000, then 00001;
  - retire pulses at cycle 5, instret_cnt=1, cycle_cnt=5.
- beq 0x112A0003 followed by sw 0xAD280004 with no stalls:
  - beq occupies 3 cycles; sw occupies 4 cycles with last_phase=1 at p3;
  - instret_cnt=2 after 7 cycles.
- lw 0x8D280004 with mem_ready low 2 cycles in p0 and 3 cycles in p3:
  - p0 held 3 cycles, p3 held 4 cycles, total 10 cycles;
  - op=100011 stable from p1 through p4.
- Illegal 0xFC000000 (op 111111), then 0x00000022 (R-type funct 100010):
  - each runs p0-p1 and pulses illegal_op;
  - instret_cnt stays 0, p returns to 00001.
- Reset asserted during p3 of j 0x08000010:
  - next cycle p=00001, counters=0, IR=0, retire=0;
  - the following fetch proceeds normally.
- Preload cycle_cnt near wrap (force 32'hFFFFFFFE) and run 3 cycles:
  - cycle_cnt reads 32'h00000001 with no other side effects.
